dbus_master: RTL and testbench

Data-bus initiator for the MEM stage of the pipeline. It turns load/store requests of byte, half or word size into word-aligned transactions on the data bus. The bus is served by `RAM` or any other responder using the address/data/rw/en/miss protocol. Sub-word stores use read-modify-write because the bus has no byte enables. The block holds `busy` to stall the pipeline until the transaction completes.

---
 rtl/dbus_master.sv | 133 +++++++++++++
 tb/tb_dbus_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dbus_master.sv
// dbus_master: MEM-stage data-bus initiator with read-modify-write sub-word stores.
// Optional miss timeout abort when DBUS_TIMEOUT_EN is defined.
module dbus_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic                  dbus_en,
  output logic                  dbus_rw,
  output logic [ADDR_WIDTH-1:0] dbus_addr,
  output logic [31:0]           dbus_wdata,
  input  logic [31:0]           dbus_rdata,
  input  logic                  dbus_miss
);
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;
  state_t                state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d, en_q, en_d, rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  mis, tmo;
  logic [4:0]            sh;
  logic [7:0]            lb;
  logic [15:0]           lh;
  logic [31:0]           mask, merged, load;
  assign mis = (req_size == 2'b11) | ((req_size == 2'b01) & req_addr[0]) |
               ((req_size == 2'b10) & (|req_addr[1:0]));
  assign sh = (req_size == 2'b00) ? {req_addr[1:0], 3'b000} : {req_addr[1], 4'b0000};
  assign lb = dbus_rdata[{req_addr[1:0], 3'b000} +: 8];
  assign lh = dbus_rdata[{req_addr[1], 4'b0000} +: 16];
  assign load = (req_size == 2'b00) ? {{24{req_signed & lb[7]}}, lb} :
                (req_size == 2'b01) ? {{16{req_signed & lh[15]}}, lh} : dbus_rdata;
  assign mask = ((req_size == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign merged = (dbus_rdata & ~mask) | ((req_wdata << sh) & mask);
`ifdef DBUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  // Counter restarts whenever the state changes, so each bus phase gets its own budget
  assign cnt_d = (state_d != state_q) ? '0 : cnt_q + 16'(busy_q & dbus_miss);
  assign tmo = busy_q & dbus_miss & (cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    en_d    = en_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (mis) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = !req_we ? RD : (req_size == 2'b10) ? WR : RMW_RD;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          rw_d    = req_we & (req_size == 2'b10);
          addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = req_wdata;
        end
      end
      RD, RMW_RD, WR: if (tmo || !dbus_miss) begin
        if (!tmo && state_q == RMW_RD) begin
          state_d = WR;
          rw_d    = 1'b1;
          wdata_d = merged;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = tmo;
          busy_d  = 1'b0;
          en_d    = 1'b0;
          rw_d    = 1'b0;
          rdata_d = (!tmo && state_q == RD) ? load : rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef DBUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign dbus_en    = en_q;
  assign dbus_rw    = rw_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;
endmodule

// File: tb/tb_dbus_master.sv
// tb_dbus_master: randomized bench for dbus_master against a byte-lane memory model.
module tb_dbus_master;
`ifdef DBUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 1000;
`endif
  logic        Clk = 1'b0, Rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        busy, done, err, dbus_en, dbus_rw;
  logic [31:0] rdata, dbus_addr, dbus_wdata;
  logic [31:0] dbus_rdata = '0;
  logic        dbus_miss = 1'b0;
  logic [31:0] mem [0:255];
  logic [31:0] exp_rdata = '0;
  int          tests = 0, fails = 0;

  always #5 Clk = ~Clk;

  dbus_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .dbus_en(dbus_en), .dbus_rw(dbus_rw),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
    .dbus_miss(dbus_miss)
  );

  // mrd/mwr: misses per read/write phase (-1 = random); keep: leave request for back-to-back
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int mrd, input int mwr, input bit keep, input int extra);
    logic        mis;
    logic [31:0] old, expld, newword;
    logic [7:0]  b [4];
    logic [65:0] snap;
    logic        prev_miss, m, tmo_hit, is_wr;
    int          lane, n, nphase, phase, pm, total, cyc, lim, lat;
    mis = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    old = mem[addr[9:2]];
    lane = int'(addr[1:0]);
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    nphase = !we ? 1 : (size == 2'd2) ? 1 : 2;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    expld = '0;
    newword = old;
    if (!mis) begin
      for (int k = 0; k < n; k++) expld = expld | (32'(b[lane+k]) << (8*k));
      if (sgn && n < 4 && b[lane+n-1][7]) expld = expld - (32'd1 << (8*n));
      for (int k = 0; k < n; k++) b[lane+k] = wdata[8*k +: 8];
      newword = {b[3], b[2], b[1], b[0]};
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; dbus_miss = 1'b0;
    phase = 0; pm = 0; total = 0; prev_miss = 1'b0; tmo_hit = 1'b0; snap = '0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge Clk);
      if (done) break;
      if (prev_miss) begin
        tests++;
        if ({dbus_en, dbus_rw, dbus_addr, dbus_wdata} !== snap) begin
          fails++; $display("FAIL hold_on_miss: got %h required %h", {dbus_en, dbus_rw, dbus_addr, dbus_wdata}, snap);
        end
      end
      prev_miss = 1'b0;
      if (dbus_en && (mis || tmo_hit || phase >= nphase)) begin
        tests++; fails++;
        $display("FAIL spurious_en: dbus_en=1 required 0 (addr %h phase %0d)", addr, phase);
      end else if (dbus_en) begin
        is_wr = we && (size == 2'd2 || phase == 1);
        tests++;
        if (dbus_addr !== {addr[31:2], 2'b00} || dbus_rw !== is_wr) begin
          fails++; $display("FAIL bus_req: addr %h rw %b required addr %h rw %b", dbus_addr, dbus_rw, {addr[31:2], 2'b00}, is_wr);
        end
        lim = is_wr ? mwr : mrd;
        m = (lim < 0) ? (pm < 3 && $urandom_range(0, 3) == 0) : (pm < lim);
        dbus_miss = m;
        snap = {dbus_en, dbus_rw, dbus_addr, dbus_wdata};
        prev_miss = m;
        if (m) begin
          pm++; total++;
          dbus_rdata = $urandom;
          if (pm == TO) begin tmo_hit = 1'b1; prev_miss = 1'b0; end
        end else if (!is_wr) begin
          dbus_rdata = mem[addr[9:2]];
          phase++; pm = 0;
        end else begin
          tests++;
          if (dbus_wdata !== newword) begin
            fails++; $display("FAIL write_data: got %h required %h", dbus_wdata, newword);
          end
          mem[addr[9:2]] = newword;
          phase++; pm = 0;
        end
      end else begin
        dbus_miss = 1'(($urandom_range(0, 1)));
        dbus_rdata = $urandom;
      end
    end
    dbus_miss = 1'b0;
    lat = extra + (mis ? 1 : 1 + (tmo_hit ? phase : nphase) + total);
    tests++;
    if (!done || cyc != lat) begin
      fails++; $display("FAIL latency: done=%b after %0d cycles required %0d", done, cyc, lat);
    end
    tests++;
    if (err !== (mis | tmo_hit) || busy !== 1'b0 || dbus_en !== 1'b0) begin
      fails++; $display("FAIL completion: err %b busy %b en %b required err %b busy 0 en 0", err, busy, dbus_en, mis | tmo_hit);
    end
    if (!we && !mis && !tmo_hit) exp_rdata = expld;
    tests++;
    if (rdata !== exp_rdata) begin
      fails++; $display("FAIL rdata: got %h required %h", rdata, exp_rdata);
    end
    if (!tmo_hit) begin
      tests++;
      if (phase != (mis ? 0 : nphase)) begin
        fails++; $display("FAIL bus_phases: got %0d required %0d", phase, mis ? 0 : nphase);
      end
    end
    if (!keep) begin
      req_valid = 1'b0;
      @(negedge Clk);
      tests++;
      if (done !== 1'b0) begin
        fails++; $display("FAIL done_pulse: done %b required 0", done);
      end
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    tests++;
    if ({busy, done, err, dbus_en, dbus_rw, dbus_addr, dbus_wdata, rdata} !== '0) begin
      fails++; $display("FAIL reset: outputs %h required 0", {busy, done, err, dbus_en, dbus_rw, dbus_addr, dbus_wdata, rdata});
    end
    Rst = 1'b0;
    exp_rdata = '0;
    @(negedge Clk);
  endtask

  task automatic test_directed;
    mem[64] = 32'hDEADBEEF;
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 1'b0, 0);
    mem[64] = 32'h80112233;
    run_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, 1'b0, 0);
    tests++;
    if (rdata !== 32'hFFFFFF80) begin fails++; $display("FAIL sbyte: got %h required ffffff80", rdata); end
    run_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0, 1'b0, 0);
    tests++;
    if (rdata !== 32'h00000080) begin fails++; $display("FAIL ubyte: got %h required 00000080", rdata); end
    mem[128] = 32'h11223344;
    run_req(1'b1, 2'd1, 1'b0, 32'h202, 32'hABCD, 1, 0, 1'b0, 0);
    tests++;
    if (mem[128] !== 32'hABCD3344) begin fails++; $display("FAIL rmw_half: got %h required abcd3344", mem[128]); end
    run_req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 0, 1'b0, 0);
    run_req(1'b1, 2'd2, 1'b0, 32'h104, 32'h12345678, 0, 3, 1'b0, 0);
    run_req(1'b1, 2'd3, 1'b0, 32'h108, 32'h1, 0, 0, 1'b0, 0);
  endtask

  task automatic test_long_miss;
    run_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 10, 0, 1'b0, 0);
    run_req(1'b1, 2'd0, 1'b0, 32'h301, 32'h5A, 0, 10, 1'b0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++)
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 1023)), $urandom, -1, -1, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    run_req(1'b0, 2'd2, 1'b0, 32'h040, 32'h0, -1, -1, 1'b1, 0);
    for (int i = 0; i < 8; i++)
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 1023)), $urandom, -1, -1, i != 7, 1);
  endtask

  task automatic test_reset_mid_rmw;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h0F1; req_wdata = 32'h77;
    dbus_miss = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b1; dbus_miss = 1'b0; dbus_rdata = 32'hCAFEF00D;
    @(negedge Clk);
    tests++;
    if ({busy, done, err, dbus_en, dbus_rw, dbus_addr, dbus_wdata, rdata} !== '0) begin
      fails++; $display("FAIL reset_mid: outputs %h required 0", {busy, done, err, dbus_en, dbus_rw, dbus_addr, dbus_wdata, rdata});
    end
    Rst = 1'b0; req_valid = 1'b0; exp_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      tests++;
      if (dbus_en !== 1'b0 || done !== 1'b0) begin
        fails++; $display("FAIL no_write_after_reset: en %b done %b required 0 0", dbus_en, done);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset;
    test_directed;
    test_long_miss;
    test_random;
    test_back_to_back;
    test_reset_mid_rmw;
    run_req(1'b0, 2'd1, 1'b1, 32'h3FE, 32'h0, -1, -1, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
